// File: rtl/sc_nestscore_if.sv
// Handshake bundle between the nest checker/start button and the scoring block.
// The block owns the score/lives/side/event outputs; the environment owns the button and the nest flags.
interface sc_nestscore_if #(
   parameter int SCORE_WIDTH = 4
);
   logic                   SC_NESTSCORE_start_InLow;
   logic                   SC_NESTSCORE_check_InHigh;
   logic                   SC_NESTSCORE_nest_InLow;
   logic                   SC_NESTSCORE_left_InLow;
   logic                   SC_NESTSCORE_right_InLow;
   logic [SCORE_WIDTH-1:0] SC_NESTSCORE_score_OutBUS;
   logic [2:0]             SC_NESTSCORE_lives_OutBUS;
   logic [1:0]             SC_NESTSCORE_side_OutBUS;
   logic                   SC_NESTSCORE_hit_OutHigh;
   logic                   SC_NESTSCORE_miss_OutHigh;
   logic                   SC_NESTSCORE_win_OutHigh;
   logic                   SC_NESTSCORE_over_OutHigh;
   logic                   SC_NESTSCORE_error_OutHigh;

   modport master (
      output SC_NESTSCORE_start_InLow,
      output SC_NESTSCORE_check_InHigh,
      output SC_NESTSCORE_nest_InLow,
      output SC_NESTSCORE_left_InLow,
      output SC_NESTSCORE_right_InLow,
      input  SC_NESTSCORE_score_OutBUS,
      input  SC_NESTSCORE_lives_OutBUS,
      input  SC_NESTSCORE_side_OutBUS,
      input  SC_NESTSCORE_hit_OutHigh,
      input  SC_NESTSCORE_miss_OutHigh,
      input  SC_NESTSCORE_win_OutHigh,
      input  SC_NESTSCORE_over_OutHigh,
      input  SC_NESTSCORE_error_OutHigh
   );

   modport slave (
      input  SC_NESTSCORE_start_InLow,
      input  SC_NESTSCORE_check_InHigh,
      input  SC_NESTSCORE_nest_InLow,
      input  SC_NESTSCORE_left_InLow,
      input  SC_NESTSCORE_right_InLow,
      output SC_NESTSCORE_score_OutBUS,
      output SC_NESTSCORE_lives_OutBUS,
      output SC_NESTSCORE_side_OutBUS,
      output SC_NESTSCORE_hit_OutHigh,
      output SC_NESTSCORE_miss_OutHigh,
      output SC_NESTSCORE_win_OutHigh,
      output SC_NESTSCORE_over_OutHigh,
      output SC_NESTSCORE_error_OutHigh
   );
endinterface

// File: rtl/sc_nestscore.sv
// Nest game scorekeeper: turns nest-checker verdicts into score/lives, hit/miss pulses and win/game-over levels.
// Every output comes straight from a flop; the next-state logic below computes all *_d values at once.
module sc_nestscore #(
   parameter int SCORE_WIDTH = 4,
   parameter int LIVES_INIT  = 3,
   parameter int WIN_SCORE   = 9
) (
   input logic           SC_NESTSCORE_CLOCK_50,
   input logic           SC_NESTSCORE_RESET_InHigh,
   sc_nestscore_if.slave sc_bus
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_HIT,
      ST_MISS,
      ST_WIN,
      ST_GAMEOVER
   } state_t;

   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;
   localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);
   localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);
   localparam logic [2:0]             LIVES_LOAD = 3'(LIVES_INIT);

   state_t                 state_q, state_d;
   logic [SCORE_WIDTH-1:0] score_q, score_d;
   logic [2:0]             lives_q, lives_d;
   logic [1:0]             side_q, side_d;
   logic                   hit_q, hit_d;
   logic                   miss_q, miss_d;
   logic                   win_q, win_d;
   logic                   over_q, over_d;
   logic                   error_q, error_d;
   logic                   start_prev_q, start_prev_d;

   logic       start_event;
   logic [2:0] flags;
   logic       flags_valid;
   logic       hit_ok;

   // A press is the high-to-low transition only, so a held button counts once.
   assign start_event = start_prev_q & ~sc_bus.SC_NESTSCORE_start_InLow;

   assign flags = {sc_bus.SC_NESTSCORE_nest_InLow,
                   sc_bus.SC_NESTSCORE_left_InLow,
                   sc_bus.SC_NESTSCORE_right_InLow};

   // Exactly one side hit with nest asserted, or nothing at all, are the only coherent verdicts.
   assign flags_valid = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b111);
   assign hit_ok      = flags_valid && !sc_bus.SC_NESTSCORE_nest_InLow;

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      lives_d      = lives_q;
      side_d       = side_q;
      error_d      = error_q;
      start_prev_d = sc_bus.SC_NESTSCORE_start_InLow;
      hit_d        = 1'b0;
      miss_d       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_event) begin
               state_d = ST_PLAY;
               score_d = '0;
               side_d  = 2'b00;
               error_d = 1'b0;
               lives_d = LIVES_LOAD;
            end
         end
         ST_PLAY: begin
            // A simultaneous press beats the check: the verdict is dropped, not scored.
            if (start_event) begin
               state_d = ST_IDLE;
            end else if (sc_bus.SC_NESTSCORE_check_InHigh) begin
               if (hit_ok) begin
                  state_d = ST_HIT;
                  score_d = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_ONE;
                  side_d  = sc_bus.SC_NESTSCORE_left_InLow ? 2'b10 : 2'b01;
                  hit_d   = 1'b1;
               end else begin
                  state_d = ST_MISS;
                  lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                  miss_d  = 1'b1;
                  if (!flags_valid) begin
                     error_d = 1'b1;
                  end
               end
            end
         end
         ST_HIT: begin
            if (start_event) begin
               state_d = ST_IDLE;
            end else begin
               state_d = (score_q == WIN_VAL) ? ST_WIN : ST_PLAY;
            end
         end
         ST_MISS: begin
            if (start_event) begin
               state_d = ST_IDLE;
            end else begin
               state_d = (lives_q == 3'd0) ? ST_GAMEOVER : ST_PLAY;
            end
         end
         ST_WIN, ST_GAMEOVER: begin
            if (start_event) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      win_d  = (state_d == ST_WIN);
      over_d = (state_d == ST_GAMEOVER);
   end

   always_ff @(posedge SC_NESTSCORE_CLOCK_50) begin
      if (SC_NESTSCORE_RESET_InHigh) begin
         state_q      <= ST_IDLE;
         score_q      <= '0;
         lives_q      <= LIVES_LOAD;
         side_q       <= 2'b00;
         hit_q        <= 1'b0;
         miss_q       <= 1'b0;
         win_q        <= 1'b0;
         over_q       <= 1'b0;
         error_q      <= 1'b0;
         start_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         side_q       <= side_d;
         hit_q        <= hit_d;
         miss_q       <= miss_d;
         win_q        <= win_d;
         over_q       <= over_d;
         error_q      <= error_d;
         start_prev_q <= start_prev_d;
      end
   end

   assign sc_bus.SC_NESTSCORE_score_OutBUS  = score_q;
   assign sc_bus.SC_NESTSCORE_lives_OutBUS  = lives_q;
   assign sc_bus.SC_NESTSCORE_side_OutBUS   = side_q;
   assign sc_bus.SC_NESTSCORE_hit_OutHigh   = hit_q;
   assign sc_bus.SC_NESTSCORE_miss_OutHigh  = miss_q;
   assign sc_bus.SC_NESTSCORE_win_OutHigh   = win_q;
   assign sc_bus.SC_NESTSCORE_over_OutHigh  = over_q;
   assign sc_bus.SC_NESTSCORE_error_OutHigh = error_q;
endmodule

// File: tb/tb_sc_nestscore.sv
// Bench for sc_nestscore: directed game scenarios followed by random play, every cycle compared
// against an event-level game model (phase + pending outcome) that lives in the bench.
module tb_sc_nestscore;
   localparam int SW   = 4;
   localparam int LIV  = 3;
   localparam int WINS = 9;

   localparam int P_IDLE = 0;
   localparam int P_PLAY = 1;
   localparam int P_WIN  = 2;
   localparam int P_OVER = 3;

   logic       clk = 1'b0;
   logic       rst_in = 1'b1;
   logic       start_in = 1'b1;
   logic       check_in = 1'b0;
   logic [2:0] flags_in = 3'b111;

   int checks = 0;
   int errors = 0;

   // reference game state
   int  m_phase, m_pend, m_score, m_lives, m_side;
   bit  m_busy, m_hit, m_miss, m_err, m_prev;

   sc_nestscore_if #(.SCORE_WIDTH(SW)) bus ();

   assign bus.SC_NESTSCORE_start_InLow  = start_in;
   assign bus.SC_NESTSCORE_check_InHigh = check_in;
   assign bus.SC_NESTSCORE_nest_InLow   = flags_in[2];
   assign bus.SC_NESTSCORE_left_InLow   = flags_in[1];
   assign bus.SC_NESTSCORE_right_InLow  = flags_in[0];

   sc_nestscore #(.SCORE_WIDTH(SW), .LIVES_INIT(LIV), .WIN_SCORE(WINS)) dut (
      .SC_NESTSCORE_CLOCK_50    (clk),
      .SC_NESTSCORE_RESET_InHigh(rst_in),
      .sc_bus                   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One rising edge of game rules, stated in terms of events rather than FSM states.
   task automatic model_step();
      bit ev;
      bit valid;
      if (rst_in) begin
         m_phase = P_IDLE; m_busy = 0; m_pend = P_IDLE;
         m_score = 0; m_lives = LIV; m_side = 0;
         m_hit = 0; m_miss = 0; m_err = 0; m_prev = 1;
         return;
      end
      ev     = m_prev && !start_in;
      m_prev = start_in;
      m_hit  = 0;
      m_miss = 0;
      if (m_busy) begin
         m_busy  = 0;
         m_phase = ev ? P_IDLE : m_pend;
      end else begin
         case (m_phase)
            P_IDLE: if (ev) begin
               m_phase = P_PLAY; m_score = 0; m_side = 0; m_err = 0; m_lives = LIV;
            end
            P_PLAY: if (ev) begin
               m_phase = P_IDLE;
            end else if (check_in) begin
               valid = (flags_in == 3'b001) || (flags_in == 3'b010) || (flags_in == 3'b111);
               m_busy = 1;
               if (valid && flags_in[2] == 1'b0) begin
                  m_score = (m_score < (1 << SW) - 1) ? m_score + 1 : m_score;
                  m_side  = (flags_in[1] == 1'b0) ? 1 : 2;
                  m_hit   = 1;
                  m_pend  = (m_score == WINS) ? P_WIN : P_PLAY;
                  $display("txn t=%0t hit  score=%0d side=%0d", $time, m_score, m_side);
               end else begin
                  m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                  m_miss  = 1;
                  if (!valid) m_err = 1;
                  m_pend  = (m_lives == 0) ? P_OVER : P_PLAY;
                  $display("txn t=%0t miss lives=%0d err=%0d", $time, m_lives, m_err);
               end
            end
            default: if (ev) m_phase = P_IDLE;
         endcase
      end
   endtask

   task automatic compare_all();
      check_eq("score", int'(bus.SC_NESTSCORE_score_OutBUS), m_score);
      check_eq("lives", int'(bus.SC_NESTSCORE_lives_OutBUS), m_lives);
      check_eq("side",  int'(bus.SC_NESTSCORE_side_OutBUS),  m_side);
      check_eq("hit",   int'(bus.SC_NESTSCORE_hit_OutHigh),  int'(m_hit));
      check_eq("miss",  int'(bus.SC_NESTSCORE_miss_OutHigh), int'(m_miss));
      check_eq("win",   int'(bus.SC_NESTSCORE_win_OutHigh),  int'(!m_busy && m_phase == P_WIN));
      check_eq("over",  int'(bus.SC_NESTSCORE_over_OutHigh), int'(!m_busy && m_phase == P_OVER));
      check_eq("error", int'(bus.SC_NESTSCORE_error_OutHigh), int'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic apply(input bit s, input bit c, input logic [2:0] f, input int n);
      start_in = s;
      check_in = c;
      flags_in = f;
      repeat (n) tick();
   endtask

   task automatic press();
      apply(1'b0, 1'b0, 3'b111, 1);
      apply(1'b1, 1'b0, 3'b111, 1);
   endtask

   initial begin
      int low_cnt;
      int r;

      // reset state
      rst_in = 1'b1;
      apply(1'b1, 1'b0, 3'b111, 2);
      rst_in = 1'b0;
      check_eq("rst_lives", int'(bus.SC_NESTSCORE_lives_OutBUS), 3);
      check_eq("rst_score", int'(bus.SC_NESTSCORE_score_OutBUS), 0);
      apply(1'b1, 1'b0, 3'b111, 1);

      // first left hit
      press();
      apply(1'b1, 1'b1, 3'b001, 1);
      check_eq("hit1_pulse", int'(bus.SC_NESTSCORE_hit_OutHigh), 1);
      check_eq("hit1_score", int'(bus.SC_NESTSCORE_score_OutBUS), 1);
      check_eq("hit1_side",  int'(bus.SC_NESTSCORE_side_OutBUS), 1);
      apply(1'b1, 1'b0, 3'b111, 1);
      check_eq("hit1_once",  int'(bus.SC_NESTSCORE_hit_OutHigh), 0);

      // three clean misses -> game over, then checks ignored
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b1, 3'b111, 1);
         check_eq("miss_pulse", int'(bus.SC_NESTSCORE_miss_OutHigh), 1);
         check_eq("miss_lives", int'(bus.SC_NESTSCORE_lives_OutBUS), 2 - i);
         apply(1'b1, 1'b0, 3'b111, 3);
      end
      check_eq("over_lvl", int'(bus.SC_NESTSCORE_over_OutHigh), 1);
      apply(1'b1, 1'b1, 3'b001, 1);
      apply(1'b1, 1'b0, 3'b111, 2);
      check_eq("over_frz_score", int'(bus.SC_NESTSCORE_score_OutBUS), 1);
      check_eq("over_frz_lives", int'(bus.SC_NESTSCORE_lives_OutBUS), 0);

      // nine right hits -> win, then restart
      press();
      press();
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, 1'b1, 3'b010, 1);
         apply(1'b1, 1'b0, 3'b111, 1);
      end
      check_eq("win_lvl",   int'(bus.SC_NESTSCORE_win_OutHigh), 1);
      check_eq("win_score", int'(bus.SC_NESTSCORE_score_OutBUS), 9);
      check_eq("win_side",  int'(bus.SC_NESTSCORE_side_OutBUS), 2);
      press();
      check_eq("win_exit", int'(bus.SC_NESTSCORE_win_OutHigh), 0);
      press();
      check_eq("restart_score", int'(bus.SC_NESTSCORE_score_OutBUS), 0);
      check_eq("restart_lives", int'(bus.SC_NESTSCORE_lives_OutBUS), 3);
      check_eq("restart_side",  int'(bus.SC_NESTSCORE_side_OutBUS), 0);

      // incoherent flags -> sticky error until the next game starts
      apply(1'b1, 1'b1, 3'b000, 1);
      check_eq("err_set",   int'(bus.SC_NESTSCORE_error_OutHigh), 1);
      check_eq("err_miss",  int'(bus.SC_NESTSCORE_miss_OutHigh), 1);
      check_eq("err_lives", int'(bus.SC_NESTSCORE_lives_OutBUS), 2);
      apply(1'b1, 1'b0, 3'b111, 1);
      apply(1'b1, 1'b1, 3'b001, 1);
      apply(1'b1, 1'b0, 3'b111, 1);
      check_eq("err_sticky", int'(bus.SC_NESTSCORE_error_OutHigh), 1);
      press();
      check_eq("err_idle", int'(bus.SC_NESTSCORE_error_OutHigh), 1);
      press();
      check_eq("err_clear", int'(bus.SC_NESTSCORE_error_OutHigh), 0);

      // press coinciding with a valid check wins; held button counts once
      apply(1'b0, 1'b1, 3'b001, 1);
      check_eq("abort_nohit", int'(bus.SC_NESTSCORE_hit_OutHigh), 0);
      check_eq("abort_score", int'(bus.SC_NESTSCORE_score_OutBUS), 0);
      apply(1'b1, 1'b0, 3'b111, 1);
      apply(1'b0, 1'b0, 3'b111, 10);
      apply(1'b1, 1'b1, 3'b010, 1);
      check_eq("held_once_hit", int'(bus.SC_NESTSCORE_hit_OutHigh), 1);
      apply(1'b1, 1'b0, 3'b111, 1);

      // reset on the hit cycle
      apply(1'b1, 1'b1, 3'b001, 1);
      rst_in = 1'b1;
      apply(1'b1, 1'b0, 3'b111, 1);
      rst_in = 1'b0;
      check_eq("rst_hit_pulse", int'(bus.SC_NESTSCORE_hit_OutHigh), 0);
      check_eq("rst_hit_score", int'(bus.SC_NESTSCORE_score_OutBUS), 0);
      apply(1'b1, 1'b0, 3'b111, 1);
      check_eq("rst_after", int'(bus.SC_NESTSCORE_hit_OutHigh | bus.SC_NESTSCORE_miss_OutHigh), 0);

      // random play
      low_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         rst_in = ($urandom_range(0, 299) == 0);
         if (low_cnt > 0) begin
            start_in = 1'b0;
            low_cnt--;
         end else if ($urandom_range(0, 29) == 0) begin
            start_in = 1'b0;
            low_cnt = $urandom_range(0, 3);
         end else begin
            start_in = 1'b1;
         end
         check_in = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         if (r < 7)       flags_in = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010;
         else if (r == 7) flags_in = 3'b111;
         else             flags_in = 3'($urandom_range(0, 7));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sc_nestscore.md
SC_NESTSCORE -- requirements
Module: SC_NESTSCORE

Interface
REQ-001 Parameter SCORE_WIDTH, default 4, SHALL set the score counter width in bits.
REQ-002 Parameter LIVES_INIT, default 3, SHALL set the lives loaded on reset and game restart (range 1-7).
REQ-003 Parameter WIN_SCORE, default 9, SHALL set the score that ends the game as a win (less than 2^SCORE_WIDTH).
REQ-004 SC_NESTSCORE_CLOCK_50  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 SC_NESTSCORE_RESET_InHigh  in  1  SHALL be the reset; it is synchronous and active-high.
REQ-006 SC_NESTSCORE_start_InLow  in  1  SHALL be the start/restart button level, active-low, already debounced.
REQ-007 SC_NESTSCORE_check_InHigh  in  1  SHALL be a one-cycle strobe marking the cycle on which the nest flags are valid.
REQ-008 SC_NESTSCORE_nest_InLow, SC_NESTSCORE_left_InLow, SC_NESTSCORE_right_InLow  in  1 each  SHALL be the upstream nest-checker flags (any-hit, left-hit, right-hit), active-low.
REQ-009 SC_NESTSCORE_score_OutBUS  out  SCORE_WIDTH  SHALL be the registered hit count.
REQ-010 SC_NESTSCORE_lives_OutBUS  out  3  SHALL be the registered remaining lives.
REQ-011 SC_NESTSCORE_side_OutBUS  out  2  SHALL be the side of the last hit: 01 left, 10 right, 00 none since restart.
REQ-012 SC_NESTSCORE_hit_OutHigh / SC_NESTSCORE_miss_OutHigh  out  1 each  SHALL be one-cycle event pulses.
REQ-013 SC_NESTSCORE_win_OutHigh / SC_NESTSCORE_over_OutHigh  out  1 each  SHALL be levels, high while in WIN or GAMEOVER respectively.
REQ-014 SC_NESTSCORE_error_OutHigh  out  1  SHALL be a sticky flag for an inconsistent flag combination.

Function
REQ-015 The block SHALL implement the states IDLE, PLAY, HIT, MISS, WIN and GAMEOVER, all registered outputs.
REQ-016 A start event SHALL be a falling edge of start_InLow, detected against a registered previous sample; a held-low button SHALL produce exactly one event.
REQ-017 IDLE: on a start event, go to PLAY next cycle; the score, side and error registers SHALL clear and lives SHALL load LIVES_INIT on that transition.
REQ-018 PLAY: check_InHigh=1 with a consistent flag set (defined below) and nest_InLow=0 SHALL go to HIT; any other sampled check SHALL go to MISS.
REQ-019 Consistent flag sets SHALL be: {nest=0,left=0,right=1}, {nest=0,left=1,right=0}, {nest=1,left=1,right=1}; any other set sampled on a check SHALL set error_OutHigh and be scored as a miss.
REQ-020 On entry to HIT (cycle N+1 after a check at cycle N), the score SHALL increment by 1 (saturating at all-ones), side SHALL take the hit side, and hit_OutHigh SHALL be high for exactly that cycle.
REQ-021 From HIT, if the updated score equals WIN_SCORE go to WIN, else return to PLAY at N+2.
REQ-022 On entry to MISS, lives SHALL decrement by 1 (never below 0), and miss_OutHigh SHALL be high for exactly that cycle.
REQ-023 From MISS, if the updated lives equal 0 go to GAMEOVER, else return to PLAY at N+2.
REQ-024 check_InHigh SHALL be ignored in IDLE, HIT, MISS, WIN and GAMEOVER; at most one score/lives update SHALL occur per two cycles.
REQ-025 WIN and GAMEOVER SHALL hold score, lives and side frozen until a start event, which SHALL go to IDLE.
REQ-026 A start event in PLAY, HIT or MISS SHALL abort to IDLE; if it coincides with a check in PLAY, the start SHALL win and the check SHALL be discarded.
REQ-027 The error flag SHALL remain set until reset or the IDLE-to-PLAY transition.

Reset
REQ-028 While RESET_InHigh=1 at a rising edge: state=IDLE, score=0, lives=LIVES_INIT, side=00, hit=miss=win=over=error=0, and the start edge register SHALL load 1 (released).
REQ-029 Reset SHALL take priority over every other input, including mid-HIT or mid-MISS; no pulse SHALL be emitted in the cycle after reset.

Verification
REQ-030 Reset, start low for 1 cycle, then check with {0,0,1} -> state PLAY, then hit=1 for one cycle, score=1, side=01, back in PLAY two cycles after the check.
REQ-031 Three checks with {1,1,1} spaced 4 cycles apart -> three miss pulses, lives 3->2->1->0, over=1, further checks leave score and lives unchanged.
REQ-032 Nine right-side hits ({0,1,0}) -> score=9, side=10, win=1; start event -> IDLE; next start event -> score=0, lives=3, side=00.
REQ-033 Check with {0,0,0} -> error=1, miss pulse, lives decrement; error stays high through later hits until restart.
REQ-034 Start falling edge on the same cycle as a valid check in PLAY -> IDLE next cycle, no hit pulse, score unchanged; start held low 10 cycles -> single event only.
REQ-035 Reset asserted on the HIT cycle -> next cycle all outputs at reset values, no hit or miss pulse.
